// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer
// Sequences one vector transfer between a register-side vector and a
// single-port RAM. A store writes LANES elements one per cycle. A load
// issues LANES read addresses and gathers the returned data into load_data.
// The RAM read latency is RD_LAT cycles.
//
// Configuration macro: VMS_STRIDE_EN
//   defined   -> element address advances by the stride latched at start
//   undefined -> stride port is ignored and the address advances by 1
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   start, is_store   transfer request and direction (sampled together)
//   base_addr, stride address of element 0 and per-element increment
//   store_data        store vector, lane i at [i*ELEM_W +: ELEM_W]
//   rd_in / rd_out    destination tag, latched at start, valid with done
//   busy, stall, done transfer status; stall = start | busy
//   ram_addr, ram_wdata, ram_we, ram_rdata   RAM port
//   load_data         assembled load vector (same lane packing)
module vec_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         stride,
  input  logic [LANES*ELEM_W-1:0]   store_data,
  input  logic [4:0]                rd_in,
  output logic                      busy,
  output logic                      stall,
  output logic                      done,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [ELEM_W-1:0]         ram_wdata,
  output logic                      ram_we,
  input  logic [ELEM_W-1:0]         ram_rdata,
  output logic [LANES*ELEM_W-1:0]   load_data,
  output logic [4:0]                rd_out
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] UNIT_INC = ADDR_W'(1'b1);
`ifdef VMS_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                    state_r;
  state_t                    next_state_s;
  state_t                    start_tgt_s;
  logic                      accept_s;
  logic                      last_s;
  logic                      cap_s;
  logic                      cap_last_s;
  logic                      issue_s;
  logic [IDX_W-1:0]          idx_r;
  logic [ADDR_W-1:0]         inc_r;
  logic [LANES*ELEM_W-1:0]   sdata_r;
  logic [RD_LAT-1:0]         vld_r;
  logic [IDX_W-1:0]          tag_r [RD_LAT];
  logic                      busy_r;
  logic                      done_r;
  logic [ADDR_W-1:0]         ram_addr_r;
  logic [ELEM_W-1:0]         ram_wdata_r;
  logic                      ram_we_r;
  logic [LANES*ELEM_W-1:0]   load_data_r;
  logic [4:0]                rd_out_r;

  // A new request is only taken when no transfer is in flight.
  assign accept_s    = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign start_tgt_s = is_store ? ST_STORE : ST_LOAD;
  assign last_s      = (idx_r == LAST_IDX);
  // The oldest shift-register stage lines up with data now on ram_rdata.
  assign cap_s       = vld_r[RD_LAT-1];
  assign cap_last_s  = cap_s && (tag_r[RD_LAT-1] == LAST_IDX);
  assign issue_s     = (state_r == ST_LOAD);

  assign busy      = busy_r;
  assign done      = done_r;
  assign stall     = start | busy_r;
  assign ram_addr  = ram_addr_r;
  assign ram_wdata = ram_wdata_r;
  assign ram_we    = ram_we_r;
  assign load_data = load_data_r;
  assign rd_out    = rd_out_r;

  // Next-state decode for the transfer FSM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) next_state_s = start_tgt_s;
        else          next_state_s = ST_IDLE;
      end
      ST_STORE: begin
        if (last_s) next_state_s = ST_DONE;
        else        next_state_s = ST_STORE;
      end
      ST_LOAD: begin
        if (last_s) next_state_s = ST_DRAIN;
        else        next_state_s = ST_LOAD;
      end
      ST_DRAIN: begin
        if (cap_last_s) next_state_s = ST_DONE;
        else            next_state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (accept_s) next_state_s = start_tgt_s;
        else          next_state_s = ST_IDLE;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM state register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_STORE) || (next_state_s == ST_LOAD) ||
                 (next_state_s == ST_DRAIN);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Request latching and per-element address / write-data stepping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_r       <= '0;
      inc_r       <= '0;
      sdata_r     <= '0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_we_r    <= 1'b0;
      rd_out_r    <= 5'd0;
    end else if (accept_s) begin
      idx_r       <= '0;
      inc_r       <= STRIDE_EN ? stride : UNIT_INC;
      ram_addr_r  <= base_addr;
      ram_we_r    <= is_store;
      rd_out_r    <= rd_in;
      // The store vector is consumed lane by lane from the bottom.
      ram_wdata_r <= is_store ? store_data[ELEM_W-1:0] : '0;
      sdata_r     <= is_store ? (store_data >> ELEM_W) : '0;
    end else if ((state_r == ST_STORE) || (state_r == ST_LOAD)) begin
      if (last_s) begin
        ram_we_r <= 1'b0;
      end else begin
        idx_r       <= idx_r + 1'b1;
        ram_addr_r  <= ram_addr_r + inc_r;
        ram_wdata_r <= sdata_r[ELEM_W-1:0];
        sdata_r     <= sdata_r >> ELEM_W;
      end
    end else begin
      ram_we_r <= 1'b0;
    end
  end

  // Read tracking pipeline and load-lane capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_r       <= '0;
      load_data_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        tag_r[i] <= '0;
      end
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        vld_r[i] <= vld_r[i-1];
        tag_r[i] <= tag_r[i-1];
      end
      vld_r[0] <= issue_s;
      tag_r[0] <= idx_r;
      if (cap_s) begin
        load_data_r[int'(tag_r[RD_LAT-1]) * ELEM_W +: ELEM_W] <= ram_rdata;
      end
    end
  end

endmodule
